// File: rtl/cpu_bus_ctl.sv
// cpu_bus_ctl -- host-to-internal-bus cycle controller.
//
// Accepts one host read/write cycle at a time. Each cycle becomes one or more
// internal-bus master beats of INT_BYTES width. When the last beat has been
// acknowledged, the block waits DTACK_WS cycles and then returns dtackl to the
// host. If no ack arrives within TIMEOUT cycles of REQ entry, or of the
// previous ack, the cycle is abandoned and berrl is returned instead.
//
// Ports
//   sys_clk, resetl       clock (rising edge) and async active-low reset
//   dreqin                host cycle request (level, held until dtackl/berrl)
//   rwin, sizin, m68k     host read/write, size code, justification (latched)
//   ba, ack               internal-bus grant and beat acknowledge pulse
//   dtackl, berrl         host data-ack / bus-error (active low)
//   erd                   read-data latch enable toward the host data path
//   beat                  current beat index, for the lane mux
//   mreq/rw/w/justify     internal-bus master outputs, each with its own oe
//
// Every output is a flop. Each one is loaded from the next-state view, so the
// outputs change on the same edge as the state transition that causes them.
module cpu_bus_ctl #(
    parameter int INT_BYTES = 4,
    parameter int TIMEOUT   = 255,
    parameter int DTACK_WS  = 1,
    parameter int WCODE_W   = 4
) (
    input  logic               sys_clk,
    input  logic               resetl,
    input  logic               dreqin,
    input  logic               rwin,
    input  logic [1:0]         sizin,
    input  logic               m68k,
    input  logic               ba,
    input  logic               ack,
    output logic               dtackl,
    output logic               berrl,
    output logic               erd,
    output logic [2:0]         beat,
    output logic               mreq_out,
    output logic               mreq_oe,
    output logic               rw_out,
    output logic               rw_oe,
    output logic [WCODE_W-1:0] w_out,
    output logic               w_oe,
    output logic               justify_out,
    output logic               justify_oe
);

    localparam int LG_INT = $clog2(INT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WS,
        S_DONE,
        S_ERR
    } state_t;

    // Host request fields captured when a cycle is accepted.
    typedef struct packed {
        logic       rw;
        logic [1:0] siz;
        logic       m68k;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [2:0]  beat_q, beat_d;
    logic [15:0] tmo_q, tmo_d;
    logic [16:0] tmo_inc;
    logic [3:0]  ws_q, ws_d;
    logic        armed_q, armed_d;
    logic        ack_ok;
    logic        last_beat;
    logic        in_req_d;

    // Number of beats minus one for a given size code.
    function automatic logic [3:0] beats_m1(input logic [1:0] siz);
        if (int'(siz) <= LG_INT) return 4'd0;
        return 4'((1 << (int'(siz) - LG_INT)) - 1);
    endfunction

    // Beat width in bytes: the host size, capped at the port width.
    function automatic logic [WCODE_W-1:0] beat_code(input logic [1:0] siz);
        if (int'(siz) <= LG_INT) return WCODE_W'(1 << int'(siz));
        return WCODE_W'(INT_BYTES);
    endfunction

    // An ack counts only while a beat is actually on the bus with grant held.
    assign ack_ok    = (state_q == S_REQ) && ba && ack;
    assign last_beat = ({1'b0, beat_q} == beats_m1(req_q.siz));
    assign tmo_inc   = {1'b0, tmo_q} + 17'd1;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        ws_d    = ws_q;
        armed_d = armed_q;
        case (state_q)
            S_IDLE: begin
                // A request is taken only after an IDLE cycle with dreqin low.
                // A host that keeps dreqin high past dtackl is therefore not
                // given a second, unintended cycle.
                if (!dreqin) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    req_d   = '{rw: rwin, siz: sizin, m68k: m68k};
                    beat_d  = 3'd0;
                    tmo_d   = 16'd0;
                    ws_d    = 4'd0;
                    armed_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The ack is checked before the timeout, so an ack in the
                // expiry cycle still completes the beat.
                if (ack_ok) begin
                    tmo_d = 16'd0;
                    if (last_beat) begin
                        ws_d    = 4'd0;
                        state_d = (DTACK_WS > 0) ? S_WS : S_DONE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else begin
                    tmo_d = tmo_inc[15:0];
                    if (tmo_inc >= 17'(TIMEOUT)) state_d = S_ERR;
                end
            end
            S_WS: begin
                if (ws_q == 4'(DTACK_WS - 1)) state_d = S_DONE;
                else                          ws_d    = ws_q + 4'd1;
            end
            S_DONE: begin
                if (!dreqin) state_d = S_IDLE;
            end
            S_ERR: begin
                if (!dreqin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_req_d = (state_d == S_REQ);

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            beat_q  <= 3'd0;
            tmo_q   <= 16'd0;
            ws_q    <= 4'd0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            ws_q    <= ws_d;
            armed_q <= armed_d;
        end
    end

    // Registered outputs. Outside REQ the bus outputs return to their
    // reset values. The enables follow the grant sampled on the same edge.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            dtackl      <= 1'b1;
            berrl       <= 1'b1;
            erd         <= 1'b0;
            mreq_out    <= 1'b0;
            mreq_oe     <= 1'b0;
            rw_out      <= 1'b1;
            rw_oe       <= 1'b0;
            w_out       <= '0;
            w_oe        <= 1'b0;
            justify_out <= 1'b0;
            justify_oe  <= 1'b0;
        end else begin
            dtackl      <= !((state_d == S_DONE) && dreqin);
            berrl       <= !((state_d == S_ERR) && dreqin);
            erd         <= (state_d == S_DONE) && dreqin && req_d.rw;
            mreq_out    <= in_req_d;
            mreq_oe     <= in_req_d && ba;
            rw_out      <= in_req_d ? req_d.rw : 1'b1;
            rw_oe       <= in_req_d && ba;
            w_out       <= in_req_d ? beat_code(req_d.siz) : '0;
            w_oe        <= in_req_d && ba;
            justify_out <= in_req_d && req_d.m68k;
            justify_oe  <= in_req_d && ba;
        end
    end

    assign beat = beat_q;

endmodule

// File: tb/tb_cpu_bus_ctl.sv
// Directed bench for cpu_bus_ctl. There are two instances: u_a is a 4-byte
// port with one dtack wait state, and u_b is a 2-byte port with no wait
// state. Both use TIMEOUT = 8. They share the host and grant inputs but have
// separate dreqin and ack, so each scenario drives only one of them.
// Inputs are driven 1 ns after a rising edge, and outputs are sampled at the
// same point, after the registered outputs have settled.
module tb_cpu_bus_ctl;

    logic       sys_clk = 1'b0;
    logic       resetl  = 1'b1;
    logic       rwin    = 1'b0;
    logic [1:0] sizin   = 2'd0;
    logic       m68k    = 1'b0;
    logic       ba      = 1'b0;
    logic       dreq_a  = 1'b0;
    logic       ack_a   = 1'b0;
    logic       dreq_b  = 1'b0;
    logic       ack_b   = 1'b0;

    logic       a_dtackl, a_berrl, a_erd, a_mreq, a_mreq_oe, a_rw, a_rw_oe;
    logic       a_w_oe, a_just, a_just_oe;
    logic [2:0] a_beat;
    logic [3:0] a_w;
    logic       b_dtackl, b_berrl, b_erd, b_mreq, b_mreq_oe, b_rw, b_rw_oe;
    logic       b_w_oe, b_just, b_just_oe;
    logic [2:0] b_beat;
    logic [3:0] b_w;
    logic [3:0] a_oe, b_oe;

    int total = 0;
    int bad   = 0;

    assign a_oe = {a_mreq_oe, a_rw_oe, a_w_oe, a_just_oe};
    assign b_oe = {b_mreq_oe, b_rw_oe, b_w_oe, b_just_oe};

    always #5 sys_clk = ~sys_clk;

    cpu_bus_ctl #(.INT_BYTES(4), .TIMEOUT(8), .DTACK_WS(1), .WCODE_W(4)) u_a (
        .sys_clk(sys_clk), .resetl(resetl), .dreqin(dreq_a), .rwin(rwin),
        .sizin(sizin), .m68k(m68k), .ba(ba), .ack(ack_a),
        .dtackl(a_dtackl), .berrl(a_berrl), .erd(a_erd), .beat(a_beat),
        .mreq_out(a_mreq), .mreq_oe(a_mreq_oe), .rw_out(a_rw), .rw_oe(a_rw_oe),
        .w_out(a_w), .w_oe(a_w_oe), .justify_out(a_just), .justify_oe(a_just_oe)
    );

    cpu_bus_ctl #(.INT_BYTES(2), .TIMEOUT(8), .DTACK_WS(0), .WCODE_W(4)) u_b (
        .sys_clk(sys_clk), .resetl(resetl), .dreqin(dreq_b), .rwin(rwin),
        .sizin(sizin), .m68k(m68k), .ba(ba), .ack(ack_b),
        .dtackl(b_dtackl), .berrl(b_berrl), .erd(b_erd), .beat(b_beat),
        .mreq_out(b_mreq), .mreq_oe(b_mreq_oe), .rw_out(b_rw), .rw_oe(b_rw_oe),
        .w_out(b_w), .w_oe(b_w_oe), .justify_out(b_just), .justify_oe(b_just_oe)
    );

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        resetl = 1'b0;
        #1;
        total++; if (a_dtackl !== 1'b1) begin bad++; $display("FAIL reset_dtackl got=%0b want=1", a_dtackl); end
        total++; if (a_berrl !== 1'b1) begin bad++; $display("FAIL reset_berrl got=%0b want=1", a_berrl); end
        total++; if ({a_erd, a_mreq, a_just} !== 3'b000) begin bad++; $display("FAIL reset_erd_mreq_just got=%b want=000", {a_erd, a_mreq, a_just}); end
        total++; if (a_rw !== 1'b1) begin bad++; $display("FAIL reset_rw got=%0b want=1", a_rw); end
        total++; if ({a_w, a_beat, a_oe} !== 11'd0) begin bad++; $display("FAIL reset_w_beat_oe got=%h want=0", {a_w, a_beat, a_oe}); end
        repeat (2) @(posedge sys_clk);
        #2 resetl = 1'b1;
        tick;
    endtask

    // u_a: long read, one beat of 4 bytes, ack driven 3 cycles after REQ entry.
    task automatic test_long_read;
        rwin = 1'b1; sizin = 2'd2; m68k = 1'b0; ba = 1'b1; dreq_a = 1'b1;
        tick;
        total++; if (a_mreq !== 1'b1) begin bad++; $display("FAIL lr_mreq_e0 got=%0b want=1", a_mreq); end
        total++; if (a_w !== 4'd4) begin bad++; $display("FAIL lr_w got=%0d want=4", a_w); end
        total++; if (a_beat !== 3'd0) begin bad++; $display("FAIL lr_beat got=%0d want=0", a_beat); end
        total++; if (a_oe !== 4'hf) begin bad++; $display("FAIL lr_oe got=%h want=f", a_oe); end
        total++; if (a_rw !== 1'b1) begin bad++; $display("FAIL lr_rw got=%0b want=1", a_rw); end
        for (int i = 1; i <= 3; i++) begin
            tick;
            total++; if (a_mreq !== 1'b1) begin bad++; $display("FAIL lr_mreq_e%0d got=%0b want=1", i, a_mreq); end
        end
        ack_a = 1'b1;
        tick;
        ack_a = 1'b0;
        total++; if ({a_mreq, a_oe} !== 5'd0) begin bad++; $display("FAIL lr_release got=%b want=00000", {a_mreq, a_oe}); end
        total++; if (a_dtackl !== 1'b1) begin bad++; $display("FAIL lr_dtack_ws got=%0b want=1", a_dtackl); end
        for (int i = 0; i < 2; i++) begin
            tick;
            total++; if ({a_dtackl, a_erd} !== 2'b01) begin bad++; $display("FAIL lr_done%0d got=%b want=01", i, {a_dtackl, a_erd}); end
        end
        dreq_a = 1'b0;
        tick;
        total++; if ({a_dtackl, a_erd} !== 2'b10) begin bad++; $display("FAIL lr_drop got=%b want=10", {a_dtackl, a_erd}); end
        tick;
    endtask

    // u_b: phrase write on a 2-byte port, ack held high -> four beats.
    task automatic test_phrase_write;
        rwin = 1'b0; sizin = 2'd3; m68k = 1'b1; ba = 1'b1; dreq_b = 1'b1; ack_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++; if (b_beat !== 3'(i)) begin bad++; $display("FAIL pw_beat%0d got=%0d want=%0d", i, b_beat, i); end
            total++; if ({b_mreq, b_rw, b_erd, b_w} !== {3'b100, 4'd2}) begin bad++; $display("FAIL pw_bus%0d got=%b want=1000010", i, {b_mreq, b_rw, b_erd, b_w}); end
        end
        total++; if (b_just !== 1'b1) begin bad++; $display("FAIL pw_just got=%0b want=1", b_just); end
        tick;
        ack_b = 1'b0;
        total++; if ({b_mreq, b_dtackl, b_erd} !== 3'b000) begin bad++; $display("FAIL pw_done got=%b want=000", {b_mreq, b_dtackl, b_erd}); end
        dreq_b = 1'b0;
        tick;
        total++; if (b_dtackl !== 1'b1) begin bad++; $display("FAIL pw_drop got=%0b want=1", b_dtackl); end
        tick;
    endtask

    // u_a: no ack at all; bus error after 8 REQ cycles.
    task automatic test_timeout;
        rwin = 1'b1; sizin = 2'd2; ba = 1'b1; dreq_a = 1'b1;
        tick;
        repeat (7) tick;
        total++; if ({a_berrl, a_mreq} !== 2'b11) begin bad++; $display("FAIL to_e7 got=%b want=11", {a_berrl, a_mreq}); end
        tick;
        total++; if (a_berrl !== 1'b0) begin bad++; $display("FAIL to_berr got=%0b want=0", a_berrl); end
        total++; if ({a_mreq, a_oe} !== 5'd0) begin bad++; $display("FAIL to_release got=%b want=00000", {a_mreq, a_oe}); end
        total++; if (a_dtackl !== 1'b1) begin bad++; $display("FAIL to_dtackl got=%0b want=1", a_dtackl); end
        tick;
        total++; if (a_berrl !== 1'b0) begin bad++; $display("FAIL to_hold got=%0b want=0", a_berrl); end
        dreq_a = 1'b0;
        tick;
        total++; if (a_berrl !== 1'b1) begin bad++; $display("FAIL to_drop got=%0b want=1", a_berrl); end
        tick;
    endtask

    // u_a: phrase read (two beats), with grant dropped for some cycles.
    task automatic test_ba_toggle;
        rwin = 1'b1; sizin = 2'd3; ba = 1'b1; dreq_a = 1'b1;
        tick;
        total++; if ({a_oe, a_beat} !== {4'hf, 3'd0}) begin bad++; $display("FAIL ba_e0 got=%b want=1111000", {a_oe, a_beat}); end
        ba = 1'b0; ack_a = 1'b1;
        tick;
        total++; if ({a_oe, a_mreq, a_beat} !== {4'h0, 1'b1, 3'd0}) begin bad++; $display("FAIL ba_lost_ack got=%b want=00001000", {a_oe, a_mreq, a_beat}); end
        ba = 1'b1; ack_a = 1'b0;
        tick;
        total++; if ({a_oe, a_beat} !== {4'hf, 3'd0}) begin bad++; $display("FAIL ba_back got=%b want=1111000", {a_oe, a_beat}); end
        ack_a = 1'b1;
        tick;
        total++; if ({a_oe, a_beat, a_w} !== {4'hf, 3'd1, 4'd4}) begin bad++; $display("FAIL ba_beat1 got=%b want=11110010100", {a_oe, a_beat, a_w}); end
        ba = 1'b0; ack_a = 1'b0;
        tick;
        total++; if ({a_oe, a_mreq, a_beat} !== {4'h0, 1'b1, 3'd1}) begin bad++; $display("FAIL ba_lost2 got=%b want=00001001", {a_oe, a_mreq, a_beat}); end
        ba = 1'b1; ack_a = 1'b1;
        tick;
        ack_a = 1'b0;
        total++; if ({a_mreq, a_oe} !== 5'd0) begin bad++; $display("FAIL ba_ws got=%b want=00000", {a_mreq, a_oe}); end
        tick;
        total++; if ({a_dtackl, a_erd} !== 2'b01) begin bad++; $display("FAIL ba_done got=%b want=01", {a_dtackl, a_erd}); end
        dreq_a = 1'b0;
        tick;
        tick;
    endtask

    // u_a: ack arrives in the very cycle the counter reaches TIMEOUT.
    task automatic test_ack_at_timeout;
        rwin = 1'b1; sizin = 2'd2; ba = 1'b1; dreq_a = 1'b1;
        tick;
        repeat (7) tick;
        ack_a = 1'b1;
        tick;
        ack_a = 1'b0;
        total++; if ({a_berrl, a_mreq} !== 2'b10) begin bad++; $display("FAIL at_edge got=%b want=10", {a_berrl, a_mreq}); end
        tick;
        total++; if ({a_berrl, a_dtackl} !== 2'b10) begin bad++; $display("FAIL at_done got=%b want=10", {a_berrl, a_dtackl}); end
        dreq_a = 1'b0;
        tick;
        tick;
    endtask

    // u_b: host drops dreqin while the beat is still pending.
    task automatic test_early_drop;
        rwin = 1'b0; sizin = 2'd1; ba = 1'b1; dreq_b = 1'b1;
        tick;
        total++; if (b_w !== 4'd2) begin bad++; $display("FAIL ed_w got=%0d want=2", b_w); end
        dreq_b = 1'b0;
        tick;
        total++; if (b_mreq !== 1'b1) begin bad++; $display("FAIL ed_still_req got=%0b want=1", b_mreq); end
        ack_b = 1'b1;
        tick;
        ack_b = 1'b0;
        total++; if ({b_mreq, b_dtackl} !== 2'b01) begin bad++; $display("FAIL ed_done got=%b want=01", {b_mreq, b_dtackl}); end
        tick;
        total++; if (b_dtackl !== 1'b1) begin bad++; $display("FAIL ed_idle got=%0b want=1", b_dtackl); end
        tick;
    endtask

    // u_b: byte read, then a request raised with no IDLE/dreqin=0 gap.
    task automatic test_rearm;
        rwin = 1'b1; sizin = 2'd0; m68k = 1'b1; ba = 1'b1; dreq_b = 1'b1;
        tick;
        total++; if ({b_mreq, b_w, b_just} !== {1'b1, 4'd1, 1'b1}) begin bad++; $display("FAIL ra_byte got=%b want=100011", {b_mreq, b_w, b_just}); end
        ack_b = 1'b1;
        tick;
        ack_b = 1'b0;
        total++; if ({b_dtackl, b_erd} !== 2'b01) begin bad++; $display("FAIL ra_done got=%b want=01", {b_dtackl, b_erd}); end
        dreq_b = 1'b0;
        tick;
        dreq_b = 1'b1;
        tick;
        total++; if (b_mreq !== 1'b0) begin bad++; $display("FAIL ra_noaccept1 got=%0b want=0", b_mreq); end
        tick;
        total++; if (b_mreq !== 1'b0) begin bad++; $display("FAIL ra_noaccept2 got=%0b want=0", b_mreq); end
        dreq_b = 1'b0;
        tick;
        dreq_b = 1'b1;
        tick;
        total++; if (b_mreq !== 1'b1) begin bad++; $display("FAIL ra_accept got=%0b want=1", b_mreq); end
        ack_b = 1'b1;
        tick;
        ack_b = 1'b0;
        dreq_b = 1'b0;
        tick;
        tick;
    endtask

    // u_a: asynchronous reset in the middle of a two-beat cycle.
    task automatic test_reset_mid;
        rwin = 1'b0; sizin = 2'd3; m68k = 1'b1; ba = 1'b1; dreq_a = 1'b1;
        tick;
        ack_a = 1'b1;
        tick;
        ack_a = 1'b0;
        total++; if (a_beat !== 3'd1) begin bad++; $display("FAIL rm_pre_beat got=%0d want=1", a_beat); end
        #2 resetl = 1'b0;
        #1;
        total++; if ({a_mreq, a_beat, a_oe, a_w} !== 12'd0) begin bad++; $display("FAIL rm_bus got=%h want=0", {a_mreq, a_beat, a_oe, a_w}); end
        total++; if ({a_rw, a_dtackl, a_berrl, a_just, a_erd} !== 5'b11100) begin bad++; $display("FAIL rm_ctl got=%b want=11100", {a_rw, a_dtackl, a_berrl, a_just, a_erd}); end
        #3 resetl = 1'b1;
        tick;
        total++; if ({a_mreq, a_beat, a_w} !== {1'b1, 3'd0, 4'd4}) begin bad++; $display("FAIL rm_fresh got=%b want=10000100", {a_mreq, a_beat, a_w}); end
        ack_a = 1'b1;
        tick;
        tick;
        ack_a = 1'b0;
        tick;
        total++; if ({a_dtackl, a_erd} !== 2'b00) begin bad++; $display("FAIL rm_done got=%b want=00", {a_dtackl, a_erd}); end
        dreq_a = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        #2;
        test_reset();
        test_long_read();
        test_phrase_write();
        test_timeout();
        test_ba_toggle();
        test_ack_at_timeout();
        test_early_drop();
        test_rearm();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_bus_ctl.md
# cpu_bus_ctl

Parametrised host-to-internal-bus cycle controller, successor to the fixed-width CPU interface. It accepts host read/write cycles (request, read/write, size) and converts them into one or more internal-bus master beats of the internal port width. It drives mreq/rw/width/justify with output enables and returns dtackl or berrl to the host. New behaviour over the previous block:

- configurable internal port width, with automatic splitting of wide host transfers into beats;
- a programmable ack timeout with bus-error return;
- programmable dtack wait states.

## Interface

Parameters:

- INT_BYTES, 4, internal port width in bytes; legal values 1, 2, 4, 8.
- TIMEOUT, 255, REQ-state cycles without ack before abort; legal range 1..65535.
- DTACK_WS, 1, wait cycles between the final ack and dtackl; legal range 0..15.
- WCODE_W, 4, width of the w_out transfer-width code.

Ports:

- sys_clk in 1: the single clock; all logic is on the rising edge.
- resetl in 1: asynchronous active-low reset.
- dreqin in 1: host cycle request, level. The host holds it until it sees dtackl or berrl, then drops it.
- rwin in 1: 1 = read, 0 = write. Sampled at accept.
- sizin in 2: transfer size. 0 = byte, 1 = word, 2 = long, 3 = phrase (8 bytes). Sampled at accept.
- m68k in 1: host justification mode. Sampled at accept.
- ba in 1: internal-bus grant.
- ack in 1: internal-bus beat acknowledge, one-cycle pulse. Ignored unless state = REQ and ba = 1.
- dtackl out 1: host data acknowledge, active low.
- berrl out 1: host bus error, active low.
- erd out 1: read-data latch enable toward the host data path.
- beat out 3: index of the current beat, for the data-path lane mux.
- mreq_out, mreq_oe out 1, 1: internal memory request and its enable.
- rw_out, rw_oe out 1, 1: internal read/write and its enable.
- w_out, w_oe out WCODE_W, 1: beat size in bytes (1, 2, 4 or 8) and its enable.
- justify_out, justify_oe out 1, 1: justification flag and its enable.

## Operation

- Derived quantities:
  - size_bytes = 1 << sizin.
  - beat_bytes = min(size_bytes, INT_BYTES).
  - nbeats = max(1, size_bytes / INT_BYTES); maximum is 8.
- IDLE:
  - Outputs: dtackl = 1, berrl = 1, erd = 0, mreq_out = 0, all oe = 0.
  - On dreqin = 1: latch rwin, sizin and m68k; clear beat and the timeout counter; go to REQ.
- REQ:
  - mreq_out = 1, rw_out = latched rw, w_out = beat_bytes, justify_out = latched m68k.
  - All four oe signals = ba. Outputs are released while grant is lost.
  - Timeout counter increments every cycle spent in REQ and clears on each accepted ack.
  - Accepted ack with beat < nbeats-1: increment beat, stay in REQ. The next beat is requested in the following cycle.
  - Accepted ack on the last beat: go to WS if DTACK_WS > 0, otherwise to DONE.
  - Counter reaching TIMEOUT with no ack in the same cycle: go to ERR. If ack and expiry coincide, ack wins.
- WS:
  - mreq_out = 0 and all oe = 0.
  - Count DTACK_WS cycles, then go to DONE.
- DONE:
  - dtackl = 0 while dreqin = 1.
  - erd = 1 while dreqin = 1, reads only.
  - On dreqin = 0: deassert both and go to IDLE.
- ERR:
  - All bus outputs are released.
  - berrl = 0 while dreqin = 1. On dreqin = 0, go to IDLE.
- Host drops dreqin early (while in REQ or WS): the internal cycle still completes, since the internal bus cannot be aborted. DONE then sees dreqin = 0 and returns to IDLE without asserting dtackl.
- Reset values: dtackl = 1, berrl = 1, erd = 0, mreq_out = 0, rw_out = 1, w_out = 0, justify_out = 0, beat = 0, every oe = 0, state = IDLE.
- An assertion of resetl in any state forces the reset values immediately (asynchronous). No partial beat is retried after reset.

## Timing

- Edge 0 samples dreqin = 1; mreq_out is high after edge 0.
- Single beat, ack sampled at edge a:
  - mreq_out drops after edge a.
  - dtackl goes low after edge a+DTACK_WS.
- Back-to-back beats: mreq_out stays high continuously; beat and w_out update on the edge after each ack.
- A new cycle cannot be accepted until one IDLE cycle with dreqin = 0 has occurred.
- Timeout: berrl goes low after the edge where the counter equals TIMEOUT, i.e. TIMEOUT cycles after REQ entry or after the last accepted ack.
- All outputs are registered.

## Test plan

- INT_BYTES = 4, DTACK_WS = 1, long read. ba = 1, ack 3 cycles after REQ entry.
  - Required: mreq_out for 4 cycles, w_out = 4, beat = 0.
  - Required: dtackl low 2 cycles after ack, erd = 1 until dreqin drops.
- INT_BYTES = 2, phrase write, ack every cycle.
  - Required: 4 beats with beat = 0, 1, 2, 3 and w_out = 2 throughout.
  - Required: mreq_out continuous for 4 cycles, rw_out = 0, erd never asserted.
- TIMEOUT = 8, no ack.
  - Required: berrl low 8 cycles after REQ entry; mreq_out and all oe = 0.
  - Required: dtackl stays 1; berrl returns to 1 when dreqin drops.
- ba toggled 0/1 during REQ.
  - Required: all oe track ba.
  - Required: an ack while ba = 0 is ignored and beat does not advance.
- Ack in the same cycle the counter reaches TIMEOUT: transfer completes normally and berrl stays 1.
- resetl pulsed low in the middle of REQ: all outputs take their reset values immediately; the next dreqin starts a fresh cycle with beat = 0.
